// File: rtl/mmio_regfile_bank_pkg.sv
// Shared constants and helpers for the memory-mapped register bank:
// default window placement, byte-lane merge and unsigned window decode.
package regfile_pkg;

    localparam int DEF_DEPTH = 32;
    localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFFFA40;

    // Helpers work on the widest supported operands; callers size-cast in and out.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W = MAX_DATA_W / 8;
    localparam int MAX_ADDR_W = 64;

    function automatic logic [MAX_DATA_W-1:0] merge_be(
        input logic [MAX_DATA_W-1:0] old_val,
        input logic [MAX_DATA_W-1:0] new_val,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < MAX_BE_W; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Offset is formed only once addr >= base, so the top of the address space cannot wrap.
    function automatic logic in_window(
        input logic [MAX_ADDR_W-1:0] addr,
        input logic [MAX_ADDR_W-1:0] base,
        input logic [MAX_ADDR_W-1:0] depth
    );
        logic hit;
        if (addr >= base) begin
            hit = ((addr - base) < depth);
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/mmio_regfile_bank_rd_port.sv
// One registered read port: window decode, write-first bypass and
// the output register carrying data, valid and error.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_rd_en,
    input  logic [ADDR_W-1:0]       i_rd_addr,
    input  logic [DEPTH*DATA_W-1:0] i_regs,
    input  logic                    i_wr_accept,
    input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
    input  logic [DATA_W/8-1:0]     i_wr_be,
    input  logic [DATA_W-1:0]       i_wr_data,
    output logic [DATA_W-1:0]       o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_rd_err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_cur;
    logic [DATA_W-1:0] w_next;

    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_err;

    // Decode and pick the value to return, merging a same-cycle accepted write.
    always_comb begin
        w_hit = in_window(MAX_ADDR_W'(i_rd_addr), MAX_ADDR_W'(BASE_ADDR), MAX_ADDR_W'(DEPTH));
        w_idx = IDX_W'(i_rd_addr - BASE_ADDR);
        w_cur = i_regs[w_idx*DATA_W +: DATA_W];
        if (!w_hit) begin
            w_next = {DATA_W{1'b0}};
        end else if (i_wr_accept && (i_wr_idx == w_idx)) begin
            w_next = DATA_W'(merge_be(MAX_DATA_W'(w_cur), MAX_DATA_W'(i_wr_data), MAX_BE_W'(i_wr_be)));
        end else begin
            w_next = w_cur;
        end
    end

    // Response register; data holds when the port is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data  <= {DATA_W{1'b0}};
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_next;
                r_rd_err  <= ~w_hit;
            end else begin
                r_rd_err  <= 1'b0;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_err   = r_rd_err;

endmodule

// File: rtl/mmio_regfile_bank.sv
// Memory-mapped register bank: byte-enabled write port, NUM_RD registered
// read ports, per-register read-only mask, out-of-window accesses flagged.
module mmio_regfile_bank
    import regfile_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter int                NUM_RD    = 2,
    parameter logic [DEPTH-1:0]  RO_MASK   = '0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_err,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0]       r_regs [DEPTH];
    logic                    r_wr_err;

    logic [DEPTH*DATA_W-1:0] w_regs_flat;
    logic                    w_wr_hit;
    logic [IDX_W-1:0]        w_wr_idx;
    logic                    w_wr_accept;
    logic [DATA_W-1:0]       w_wr_merged;

    // Write decode: read-only targets are rejected exactly like misses.
    always_comb begin
        w_wr_hit    = in_window(MAX_ADDR_W'(wr_addr), MAX_ADDR_W'(BASE_ADDR), MAX_ADDR_W'(DEPTH));
        w_wr_idx    = IDX_W'(wr_addr - BASE_ADDR);
        w_wr_accept = wr_en & w_wr_hit & ~RO_MASK[w_wr_idx];
        w_wr_merged = DATA_W'(merge_be(MAX_DATA_W'(r_regs[w_wr_idx]), MAX_DATA_W'(wr_data),
                                       MAX_BE_W'(wr_be)));
    end

    // Storage array and write-error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_wr_err <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_regs[w_wr_idx] <= w_wr_merged;
            end
            r_wr_err <= wr_en & ~w_wr_accept;
        end
    end

    assign wr_err = r_wr_err;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign w_regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_rd_port #(
            .DATA_W    (DATA_W),
            .ADDR_W    (ADDR_W),
            .DEPTH     (DEPTH),
            .BASE_ADDR (BASE_ADDR)
        ) u_rd_port (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_rd_en     (rd_en[p]),
            .i_rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
            .i_regs      (w_regs_flat),
            .i_wr_accept (w_wr_accept),
            .i_wr_idx    (w_wr_idx),
            .i_wr_be     (wr_be),
            .i_wr_data   (wr_data),
            .o_rd_data   (rd_data[p*DATA_W +: DATA_W]),
            .o_rd_valid  (rd_valid[p]),
            .o_rd_err    (rd_err[p])
        );
    end

endmodule

// File: doc/mmio_regfile_bank.md
Name: mmio_regfile_bank

Overview:
Parametrised memory-mapped register bank: DEPTH words of DATA_W bits, decoded from a base-address window on a full-width bus address.
- One write port with byte enables; NUM_RD independent read ports with one-cycle registered read and valid strobe.
- Per-register read-only mask; out-of-window and illegal accesses are flagged, never trapped.
- Sits between the bus/peripheral decode logic and the peripheral datapaths, replacing the fixed 32x32 unregistered register file.

Parameters:
DATA_W, 32, register/data width; multiple of 8
ADDR_W, 32, bus address width
DEPTH, 32, number of registers; power of 2, 2..256
BASE_ADDR, 32'hFFFFFA40, first address of window; aligned to DEPTH
NUM_RD, 2, number of read ports, 1..4
RO_MASK, {DEPTH{1'b0}}, bit i = 1 makes reg i read-only from the write port
RESET_VAL, {DATA_W{1'b0}}, value loaded into every register on reset

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
wr_en  in  1  write request, sampled every cycle
wr_addr  in  ADDR_W  write byte-agnostic word address
wr_be  in  DATA_W/8  byte enables, bit b covers bits [8b+7:8b]
wr_data  in  DATA_W  write data
wr_err  out  1  one-cycle pulse: previous-cycle write rejected
rd_en  in  NUM_RD  per-port read request
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed registered read data
rd_valid  out  NUM_RD  one-cycle pulse: rd_data for port i valid
rd_err  out  NUM_RD  one-cycle pulse alongside rd_valid: read was out of window

Behaviour:
- Clock is clk; reset is synchronous and active-low (rst_n). Sampled only on rising clk; no asynchronous path.
- Reset: all registers = RESET_VAL; rd_data = 0; rd_valid = 0; rd_err = 0; wr_err = 0. Requests presented in the reset cycle are dropped, with no response afterwards.
- Decode: hit when BASE_ADDR <= addr <= BASE_ADDR+DEPTH-1.
  - Compare is unsigned, full ADDR_W, and must not overflow at the 32'hFFFFFFFF end.
  - Index = (addr - BASE_ADDR)[$clog2(DEPTH)-1:0].
- Write, cycle N, wr_en=1:
  - Hit and RO_MASK[idx]=0: from edge N, regs[idx] bytes with wr_be=1 take wr_data; other bytes are unchanged.
  - wr_be=0 with a hit is a legal no-op and gives no error.
  - Miss, or hit with RO_MASK[idx]=1: no register changes; wr_err=1 in cycle N+1 only.
- Read, cycle N, rd_en[i]=1:
  - rd_valid[i]=1 in cycle N+1; rd_data[i] = register value; rd_err[i]=0.
  - Miss: rd_data[i]=0 and rd_err[i]=1 in N+1.
  - When rd_en[i]=0, rd_valid[i]=0 and rd_data[i] holds its last value.
- Read/write collision (same cycle, same hit index, write accepted): the read returns the post-write value, byte-merged by wr_be (write-first bypass). A rejected write gives no bypass.
- Multiple ports reading the same index in the same cycle all get identical data.
- Back-to-back reads every cycle are fully pipelined: one response per port per cycle, no stall, no backpressure.
- rst_n low while requests are in flight: next cycle's rd_valid, rd_err and wr_err are 0.
- Registers are flops, not inferred RAM. Read-only registers still hold RESET_VAL and can be altered only by reset.

Decomposition:
- Shared package regfile_pkg: default BASE_ADDR and DEPTH constants, byte-merge function merge_be(old, new, be), and an in-window decode function.
- One sub-module, regfile_rd_port: decode + bypass mux + output register for a single port. It is instantiated NUM_RD times in a generate loop.
- Write decode and the storage array stay in the top level.

Test Plan:
1. Reset, then read 32'hFFFFFA40 on port 0 -> rd_valid=1 one cycle later, rd_data=32'h0, rd_err=0. rd_valid is low in the reset cycle.
2. Write 32'hDEADBEEF to 32'hFFFFFA45 with be=4'b1111. Next cycle write 32'h00001234 with be=4'b0011 to the same address. Then read -> 32'hDEAD1234.
3. Same cycle: write 32'hCAFEF00D to 32'hFFFFFA5F (be=4'b1111); port 0 reads 32'hFFFFFA5F and port 1 reads 32'hFFFFFA5E -> port 0 gets 32'hCAFEF00D (bypass), port 1 gets 32'h0.
4. Write to 32'hFFFFFA60 and to 32'hFFFFFA3F -> wr_err pulses one cycle each and no register changes. Read 32'hFFFFFFFF -> rd_err=1, rd_data=0, rd_valid=1.
5. RO_MASK bit 3 set: write 32'h55AA55AA to 32'hFFFFFA43 -> wr_err=1, and a later read returns RESET_VAL.
6. Port 0 reads every cycle over 40 consecutive addresses while writes stream. Assert rst_n low mid-stream -> one response per cycle, matching a reference model. After reset all reads return RESET_VAL, and there is no rd_valid in the cycle after reset assertion.
